// File: rtl/monitor_clock_sequencer_if.sv
// Avalon-MM register bus between the Nios monitor and the clock sequencer.
// The master drives address/strobes/write data; the slave returns zero-wait-state read data.
interface monitor_clock_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/monitor_clock_sequencer.sv
// Stepped target-clock generator: emits a programmed number of 50% duty pulses or free-runs until STOP.
// Optional interrupt on train completion is enabled with `define MONITOR_CLOCK_SEQUENCER_IRQ_EN.
module monitor_clock_sequencer #(
    parameter int CNT_W = 32,
    parameter int HP_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    monitor_clock_sequencer_if.slave  bus,
    output logic                      out_port,
    output logic                      busy
`ifdef MONITOR_CLOCK_SEQUENCER_IRQ_EN
    ,
    output logic                      irq
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  remaining;
    logic [HP_W-1:0]   half_period;
    logic [HP_W-1:0]   phase;
    logic              free_run;
    logic              stop_pending;
    logic              done;
    logic              irq_enable;

    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_count;
    logic              wr_hp;
    logic              wr_status;
    logic              start_req;
    logic              stop_req;
    logic [HP_W-1:0]   hp_eff;
    logic [HP_W-1:0]   hp_load;
    logic              phase_zero;

    logic              start_train;
    logic              start_empty;
    logic              high_end;
    logic              train_end;
    logic              out_d;

    assign wr_en      = bus.chipselect & ~bus.write_n;
    assign wr_ctrl    = wr_en & (bus.address == 2'd0);
    assign wr_count   = wr_en & (bus.address == 2'd1);
    assign wr_hp      = wr_en & (bus.address == 2'd2);
    assign wr_status  = wr_en & (bus.address == 2'd3);
    assign start_req  = wr_ctrl & bus.writedata[0];
    assign stop_req   = wr_ctrl & bus.writedata[1];

    // A programmed half-period of zero behaves like one so a phase never collapses.
    assign hp_eff     = (half_period == '0) ? HP_W'(1) : half_period;
    assign hp_load    = hp_eff - HP_W'(1);
    assign phase_zero = (phase == '0);

    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_train = 1'b0;
        start_empty = 1'b0;
        high_end    = 1'b0;
        train_end   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    if (bus.writedata[2] || (count != '0)) begin
                        state_d     = HIGH;
                        start_train = 1'b1;
                    end else begin
                        start_empty = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (phase_zero) begin
                    state_d  = LOW;
                    high_end = 1'b1;
                end
            end
            LOW: begin
                if (phase_zero) begin
                    if (stop_pending || (!free_run && (remaining == '0))) begin
                        state_d   = IDLE;
                        train_end = 1'b1;
                    end else begin
                        state_d = HIGH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The clock output is registered so the target never sees decode glitches.
    // In IDLE it keeps the manual LEVEL from a CTRL write that does not carry START.
    always_comb begin
        out_d = out_port;
        if (state_d == HIGH) begin
            out_d = 1'b1;
        end else if (state_d == LOW) begin
            out_d = 1'b0;
        end else if ((state_q == IDLE) && wr_ctrl && !bus.writedata[0]) begin
            out_d = bus.writedata[3];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port     <= 1'b0;
            count        <= '0;
            remaining    <= '0;
            half_period  <= HP_W'(1);
            phase        <= '0;
            free_run     <= 1'b0;
            stop_pending <= 1'b0;
            done         <= 1'b0;
        end else begin
            out_port <= out_d;

            if (wr_count && (state_q == IDLE)) begin
                count <= bus.writedata[CNT_W-1:0];
            end

            if (wr_hp) begin
                half_period <= bus.writedata[HP_W-1:0];
            end

            if ((state_q == IDLE) && start_req) begin
                remaining <= count;
                free_run  <= bus.writedata[2];
            end else if (high_end && !free_run && (remaining != '0)) begin
                remaining <= remaining - CNT_W'(1);
            end

            // Every phase reloads from the live half-period, so mid-train writes apply at the next phase.
            if (start_train || ((state_q != IDLE) && phase_zero)) begin
                phase <= hp_load;
            end else if (state_q != IDLE) begin
                phase <= phase - HP_W'(1);
            end

            if (train_end) begin
                stop_pending <= 1'b0;
            end else if (stop_req && (state_q != IDLE)) begin
                stop_pending <= 1'b1;
            end

            if (start_empty || train_end) begin
                done <= 1'b1;
            end else if (start_train) begin
                done <= 1'b0;
            end else if (wr_status && bus.writedata[0]) begin
                done <= 1'b0;
            end
        end
    end

`ifdef MONITOR_CLOCK_SEQUENCER_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_enable <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (wr_status) begin
                irq_enable <= bus.writedata[1];
            end
            irq <= done & irq_enable;
        end
    end
`else
    assign irq_enable = 1'b0;
`endif

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            2'd0: bus.readdata[3:0]       = {out_port, free_run, stop_pending, busy};
            2'd1: bus.readdata[CNT_W-1:0] = remaining;
            2'd2: bus.readdata[HP_W-1:0]  = half_period;
            2'd3: bus.readdata[1:0]       = {irq_enable, done};
            default: bus.readdata         = '0;
        endcase
    end

endmodule

// File: tb/tb_monitor_clock_sequencer.sv
// Randomized self-checking bench for monitor_clock_sequencer; expected waveforms come from the
// pulse-train rules (period arithmetic), not from the design's state machine.
`timescale 1ns/1ps
module tb_monitor_clock_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic out_port;
    logic busy;
`ifdef MONITOR_CLOCK_SEQUENCER_IRQ_EN
    logic irq;
`endif

    int checks = 0;
    int errors = 0;

    monitor_clock_sequencer_if bus ();

    monitor_clock_sequencer #(
        .CNT_W(32),
        .HP_W (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .out_port(out_port),
        .busy    (busy)
`ifdef MONITOR_CLOCK_SEQUENCER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Register write; called at a negedge, returns at the negedge after the write has landed.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] addr, input logic [31:0] expected);
        logic [31:0] rd;
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        rd             = bus.readdata;
        bus.chipselect = 1'b0;
        checkOutput(tag, rd, expected);
    endtask

    // Pick a STOP cycle that lands inside the high phase of pulse p.
    function automatic int pickStop(input int p, input int hpe);
        return p * 2 * hpe + int'($urandom_range(hpe - 1, 0));
    endfunction

    // Runs one train and compares every cycle with the ideal pulse shape.
    // stopAt < 0 means no STOP; otherwise STOP is written during cycle stopAt.
    task automatic runTrain(input int count, input int hp, input bit freeRun, input int stopAt);
        int hpe;
        int period;
        int pulses;
        int total;
        hpe    = (hp == 0) ? 1 : hp;
        period = 2 * hpe;
        if (freeRun) begin
            pulses = stopAt / period + 1;
        end else begin
            pulses = count;
            if ((stopAt >= 0) && (stopAt / period + 1 < count)) pulses = stopAt / period + 1;
        end
        total = pulses * period;

        applyStimulus(2'd1, 32'(count));
        applyStimulus(2'd2, 32'(hp));
        applyStimulus(2'd0, freeRun ? 32'h5 : 32'h1);
        for (int k = 0; k < total; k++) begin
            checkOutput("train_out", {31'd0, out_port}, ((k % period) < hpe) ? 32'd1 : 32'd0);
            checkOutput("train_busy", {31'd0, busy}, 32'd1);
            if (k == stopAt) applyStimulus(2'd0, 32'h2);
            else @(negedge clk);
        end
        checkOutput("end_out", {31'd0, out_port}, 32'd0);
        checkOutput("end_busy", {31'd0, busy}, 32'd0);
        checkReg("end_status", 2'd3, 32'd1);
        checkReg("end_count", 2'd1, freeRun ? 32'(count) : 32'(count - pulses));
        checkReg("end_ctrl", 2'd0, freeRun ? 32'h4 : 32'h0);
        applyStimulus(2'd3, 32'h1);
        checkReg("done_clear", 2'd3, 32'd0);
    endtask

    initial begin
        int cnt;
        int hp;
        int stp;
        reset          = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkReg("rst_ctrl", 2'd0, 32'd0);
        checkReg("rst_count", 2'd1, 32'd0);
        checkReg("rst_hp", 2'd2, 32'd1);
        checkReg("rst_status", 2'd3, 32'd0);
        checkOutput("rst_out", {31'd0, out_port}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        runTrain(3, 2, 1'b0, -1);
        runTrain(0, 1, 1'b1, pickStop(2, 1));

        for (int t = 0; t < 6; t++) begin
            cnt = int'($urandom_range(4, 1));
            hp  = int'($urandom_range(3, 0));
            stp = ($urandom_range(2, 0) == 0) ? pickStop(int'($urandom_range(cnt - 1, 0)), (hp == 0) ? 1 : hp) : -1;
            runTrain(cnt, hp, 1'b0, stp);
        end
        for (int t = 0; t < 3; t++) begin
            hp = int'($urandom_range(3, 1));
            runTrain(int'($urandom_range(9, 0)), hp, 1'b1, pickStop(int'($urandom_range(3, 0)), hp));
        end

        // Zero-length request: manual level stays untouched and done is raised.
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd0, 32'h8);
        checkOutput("level_high", {31'd0, out_port}, 32'd1);
        applyStimulus(2'd0, 32'h1);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        checkReg("zero_done", 2'd3, 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("zero_out", {31'd0, out_port}, 32'd1);
            checkOutput("zero_busy_hold", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        applyStimulus(2'd0, 32'h0);
        checkOutput("level_low", {31'd0, out_port}, 32'd0);
        applyStimulus(2'd3, 32'h1);

`ifdef MONITOR_CLOCK_SEQUENCER_IRQ_EN
        applyStimulus(2'd3, 32'h2);
        applyStimulus(2'd1, 32'd1);
        applyStimulus(2'd2, 32'd1);
        applyStimulus(2'd0, 32'h1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("irq_busy", {31'd0, busy}, 32'd0);
        checkOutput("irq_before", {31'd0, irq}, 32'd0);
        checkReg("irq_status", 2'd3, 32'h3);
        @(negedge clk);
        checkOutput("irq_rise", {31'd0, irq}, 32'd1);
        applyStimulus(2'd3, 32'h3);
        checkOutput("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        checkOutput("irq_fall", {31'd0, irq}, 32'd0);
        checkReg("irq_en_kept", 2'd3, 32'h2);
`else
        applyStimulus(2'd3, 32'h2);
        checkReg("status_bit1", 2'd3, 32'h0);
`endif

        // Reset in the middle of a high phase must drop the clock without waiting for an edge.
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd2, 32'd4);
        applyStimulus(2'd0, 32'h1);
        for (int k = 0; k < 9; k++) begin
            checkOutput("pre_rst_out", {31'd0, out_port}, ((k % 8) < 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        checkOutput("pre_rst_high", {31'd0, out_port}, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_out", {31'd0, out_port}, 32'd0);
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        checkReg("post_rst_hp", 2'd2, 32'd1);
        checkReg("post_rst_status", 2'd3, 32'd0);
        checkReg("post_rst_count", 2'd1, 32'd0);
        checkReg("post_rst_ctrl", 2'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
